burst_req_gen: RTL and testbench

Upstream request generator that drives the valid/ready input of the two-entry counting buffer stage. On a start command it issues a programmed number of bursts. Each burst has a programmed number of beats, and consecutive bursts are separated by a programmed idle gap. It is used to exercise and throttle the buffer's write side. Beats carry a running sequence number, so the downstream stage and the bench can check ordering.

---
 rtl/burst_req_gen_pkg.sv | 12 +
 rtl/ld_dncnt.sv | 20 ++
 rtl/burst_req_gen.sv | 132 +++++++++++++
 tb/tb_burst_req_gen.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/burst_req_gen_pkg.sv
// Shared constants for the burst request generator: default widths and FSM encodings.
package burst_req_gen_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int LEN_W_DEF  = 4;
  localparam int GAP_W_DEF  = 4;

  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t BURST = 2'd1;
  localparam state_t GAP   = 2'd2;
  localparam state_t DONE  = 2'd3;
endpackage

// File: rtl/ld_dncnt.sv
// Loadable down-counter with zero flag; saturates at zero rather than wrapping.
module ld_dncnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);
  always_ff @(posedge clk) begin
    if (!rst_n)              cnt <= '0;
    else if (load)           cnt <= load_val;
    else if (dec && !zero)   cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/burst_req_gen.sv
// Burst request generator: issues num_bursts bursts of burst_len beats separated by gap_len idle cycles.
module burst_req_gen
  import burst_req_gen_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF,
  parameter int GAP_W  = GAP_W_DEF
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  burst_len_i,
  input  logic [LEN_W-1:0]  num_bursts_i,
  input  logic [GAP_W-1:0]  gap_len_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic              last_o,
  output logic              busy_o,
  output logic              done_o
);
  state_t             state, nxt;
  logic [LEN_W-1:0]   len_q;
  logic [GAP_W-1:0]   gap_q;
  logic               last_nxt;

  // Counters hold "remaining minus one", so zero marks the final beat/burst/gap cycle
  // and an all-ones config never needs an extra bit.
  logic               beat_ld, beat_dec, beat_zero;
  logic [LEN_W-1:0]   beat_ldv, beat_cnt;
  logic               bst_ld, bst_dec, bst_zero;
  logic [LEN_W-1:0]   bst_cnt;
  logic               gap_ld, gap_dec, gap_zero;
  logic [GAP_W-1:0]   gap_cnt;
  logic               unused_cnt;

  assign unused_cnt = ^{bst_cnt, gap_cnt};

  ld_dncnt #(.W(LEN_W)) u_beat (
    .clk(clk), .rst_n(arst_n), .load(beat_ld), .load_val(beat_ldv),
    .dec(beat_dec), .cnt(beat_cnt), .zero(beat_zero)
  );
  ld_dncnt #(.W(LEN_W)) u_bst (
    .clk(clk), .rst_n(arst_n), .load(bst_ld), .load_val(num_bursts_i - LEN_W'(1)),
    .dec(bst_dec), .cnt(bst_cnt), .zero(bst_zero)
  );
  ld_dncnt #(.W(GAP_W)) u_gap (
    .clk(clk), .rst_n(arst_n), .load(gap_ld), .load_val(gap_q - GAP_W'(1)),
    .dec(gap_dec), .cnt(gap_cnt), .zero(gap_zero)
  );

  always_comb begin
    nxt      = state;
    last_nxt = 1'b0;
    beat_ld  = 1'b0;
    beat_ldv = len_q - LEN_W'(1);
    beat_dec = 1'b0;
    bst_ld   = 1'b0;
    bst_dec  = 1'b0;
    gap_ld   = 1'b0;
    gap_dec  = 1'b0;
    case (state)
      IDLE: if (start_i) begin
        if (burst_len_i == '0 || num_bursts_i == '0) nxt = DONE;
        else begin
          nxt      = BURST;
          beat_ld  = 1'b1;
          beat_ldv = burst_len_i - LEN_W'(1);
          bst_ld   = 1'b1;
          last_nxt = (burst_len_i == LEN_W'(1));
        end
      end
      BURST: begin
        last_nxt = last_o;
        if (ready_i) begin
          if (!beat_zero) begin
            beat_dec = 1'b1;
            last_nxt = (beat_cnt == LEN_W'(1));
          end else begin
            // Final beat of a burst: reload now so the next burst is ready back-to-back.
            beat_ld = 1'b1;
            if (bst_zero) begin
              nxt      = DONE;
              last_nxt = 1'b0;
            end else begin
              bst_dec = 1'b1;
              if (gap_q != '0) begin
                nxt      = GAP;
                gap_ld   = 1'b1;
                last_nxt = 1'b0;
              end else last_nxt = (len_q == LEN_W'(1));
            end
          end
        end
      end
      GAP: begin
        gap_dec = 1'b1;
        if (gap_zero) begin
          nxt      = BURST;
          last_nxt = (len_q == LEN_W'(1));
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state   <= IDLE;
      len_q   <= '0;
      gap_q   <= '0;
      valid_o <= 1'b0;
      data_o  <= '0;
      last_o  <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && start_i) begin
        len_q  <= burst_len_i;
        gap_q  <= gap_len_i;
        data_o <= '0;
      end else if (valid_o && ready_i) begin
        data_o <= data_o + DATA_W'(1);
      end
      valid_o <= (nxt == BURST);
      last_o  <= last_nxt;
      busy_o  <= (nxt != IDLE);
      done_o  <= (nxt == DONE);
    end
  end
endmodule

// File: tb/tb_burst_req_gen.sv
// Scoreboard bench for burst_req_gen: expected beats queued at start, popped on each transfer.
module tb_burst_req_gen;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic          start_i = 1'b0;
  logic [3:0]    burst_len_i = '0;
  logic [3:0]    num_bursts_i = '0;
  logic [3:0]    gap_len_i = '0;
  logic          valid_o;
  logic          ready_i = 1'b1;
  logic [DW-1:0] data_o;
  logic          last_o;
  logic          busy_o;
  logic          done_o;

  int  n_vec = 0;
  int  n_err = 0;
  bit  rmode = 1'b0;
  int  q[$];
  bit  hold_chk = 1'b0;
  int  hold_data, hold_last;

  burst_req_gen #(.DATA_W(DW), .LEN_W(4), .GAP_W(4)) dut (
    .clk(clk), .arst_n(arst_n), .start_i(start_i), .burst_len_i(burst_len_i),
    .num_bursts_i(num_bursts_i), .gap_len_i(gap_len_i), .valid_o(valid_o),
    .ready_i(ready_i), .data_o(data_o), .last_o(last_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Alternating ready when rmode is set, otherwise always ready.
  initial forever begin
    @(posedge clk); #1;
    ready_i = rmode ? ~ready_i : 1'b1;
  end

  // Monitor: stall stability and in-order beat checking against the queue.
  always @(negedge clk) begin
    if (arst_n) begin
      if (hold_chk) begin
        chk("hold_valid", int'(valid_o), 1);
        chk("hold_data", int'(data_o), hold_data);
        chk("hold_last", int'(last_o), hold_last);
      end
      if (valid_o && ready_i) begin
        if (q.size() == 0) chk("extra_beat", int'(data_o), -1);
        else chk("beat", int'({last_o, data_o}), q.pop_front());
      end
      hold_chk  = valid_o && !ready_i;
      hold_data = int'(data_o);
      hold_last = int'(last_o);
    end else hold_chk = 1'b0;
  end

  task automatic run_cmd(input int l, input int b, input int g, input bit rm, input bit poke);
    int seq, cyc, exp_cyc;
    bit seen;
    seq = 0;
    if (l > 0 && b > 0)
      for (int bi = 0; bi < b; bi++)
        for (int i = 0; i < l; i++) begin
          q.push_back(((i == l - 1) ? 16 : 0) + (seq % 16));
          seq++;
        end
    exp_cyc = (l == 0 || b == 0) ? 1 : b * l + (b - 1) * g + 1;
    @(posedge clk); #1;
    rmode = rm;
    start_i = 1'b1; burst_len_i = 4'(l); num_bursts_i = 4'(b); gap_len_i = 4'(g);
    @(posedge clk); #1;
    start_i = 1'b0;
    burst_len_i = 4'($urandom); num_bursts_i = 4'($urandom); gap_len_i = 4'($urandom);
    cyc = 1; seen = 1'b0;
    while (!seen && cyc < 1000) begin
      @(negedge clk);
      if (cyc == 1) begin
        chk("start_valid", int'(valid_o), int'(exp_cyc > 1));
        chk("start_busy", int'(busy_o), 1);
      end
      if (done_o) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        cyc++;
        start_i = poke && (cyc == 3);
        if (start_i) burst_len_i = 4'd9;
      end
    end
    chk("done_seen", int'(seen), 1);
    if (!rm) chk("cycles", cyc, exp_cyc);
    @(posedge clk); #1;
    rmode = 1'b0;
    @(negedge clk);
    chk("done_pulse", int'(done_o), 0);
    chk("idle_busy", int'(busy_o), 0);
    chk("leftover", q.size(), 0);
    q.delete();
  endtask

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1 arst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_data", int'(data_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);

    run_cmd(3, 2, 2, 1'b0, 1'b0);    // basic
    run_cmd(4, 1, 0, 1'b1, 1'b0);    // backpressure
    run_cmd(2, 3, 0, 1'b0, 1'b0);    // back-to-back
    run_cmd(0, 2, 3, 1'b0, 1'b0);    // zero length
    run_cmd(3, 0, 1, 1'b0, 1'b0);    // zero bursts
    run_cmd(3, 2, 1, 1'b0, 1'b1);    // start while busy ignored
    run_cmd(15, 2, 0, 1'b0, 1'b0);   // sequence wrap
    run_cmd(1, 3, 1, 1'b1, 1'b0);    // single-beat bursts under backpressure
    run_cmd(15, 15, 15, 1'b0, 1'b0); // all-ones config

    // Reset during beat 2 of a 5-beat burst.
    q.push_back(0); q.push_back(1); q.push_back(2);
    @(posedge clk); #1;
    start_i = 1'b1; burst_len_i = 4'd5; num_bursts_i = 4'd1; gap_len_i = 4'd0;
    @(posedge clk); #1;
    start_i = 1'b0;
    k = 0;
    while (k < 20 && !(valid_o && data_o == DW'(2))) begin
      @(negedge clk); k++;
    end
    chk("reach_beat2", int'(k < 20), 1);
    arst_n = 1'b0;
    @(posedge clk); #1;
    arst_n = 1'b1;
    q.delete();
    @(negedge clk);
    chk("mid_rst_valid", int'(valid_o), 0);
    chk("mid_rst_data", int'(data_o), 0);
    chk("mid_rst_last", int'(last_o), 0);
    chk("mid_rst_busy", int'(busy_o), 0);
    chk("mid_rst_done", int'(done_o), 0);
    run_cmd(2, 1, 0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
